sw_alu_display: RTL and testbench

- Clocked, parametrised successor to the board-level switch/key/seven-segment datapath.
- Switches supply two unsigned operands A and B. Two push-keys are synchronised and debounced, and each clean press toggles one bit of a registered 2-bit mode.
- The selected arithmetic result is registered, decoded to active-low seven-segment digits, and a flag LED is driven.
- Sits directly under the board top, which only maps pins.

---
 rtl/sw_alu_display.sv | 151 +++++++++++++++
 tb/tb_sw_alu_display.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sw_alu_display.sv
`default_nettype none
// -------------------------------------------------------------------------
// sw_alu_display : switch operands -> pass/add/sub/mul -> 7-segment hex digits
// Rev 1.0 - initial release
// -------------------------------------------------------------------------
module sw_alu_display #(
  parameter int WIDTH           = 5,
  parameter int NDIGITS         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LZ_BLANK        = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*WIDTH-1:0]     sw,
  input  logic [1:0]             key,
  output logic [8*NDIGITS-1:0]   hex,
  output logic [1:0]             mode_led,
  output logic                   flag_led
);

  localparam int RW = 4 * NDIGITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  if (RW < 2 * WIDTH + 1) begin : g_bad_ndigits
    $error("sw_alu_display: NDIGITS too small to show 2*WIDTH+1 result bits");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("sw_alu_display: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [2*WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic [1:0]         key_s1_q, key_s2_q, db_dly_q, mode_q;
  logic [1:0]         db, press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= 2'b11;
      key_s2_q <= 2'b11;
      db_dly_q <= 2'b11;
      mode_q   <= 2'b00;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
      db_dly_q <= db;
      mode_q   <= mode_q ^ press;
    end
  end

  // Keys are active-low, so a press is a debounced 1->0 step.
  assign press = db_dly_q & ~db;

  for (genvar k = 0; k < 2; k++) begin : g_debounce
    logic [CW-1:0] cnt_q;
    logic          db_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        db_q  <= 1'b1;
      end else if (key_s2_q[k] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        db_q  <= key_s2_q[k];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign db[k] = db_q;
  end

  logic [WIDTH-1:0]   a, b;
  logic [WIDTH:0]     sum, diff, mag;
  logic [2*WIDTH-1:0] prod;
  logic [RW-1:0]      r_d, r_q;
  logic               flag_d, flag_q;

  assign a    = sw_s2_q[WIDTH-1:0];
  assign b    = sw_s2_q[2*WIDTH-1:WIDTH];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign mag  = diff[WIDTH] ? -diff : diff;
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    r_d    = '0;
    flag_d = 1'b0;
    case (mode_q)
      2'b00:   r_d = RW'({b, a});
      2'b01: begin
        r_d    = RW'(sum);
        flag_d = sum[WIDTH];
      end
      2'b10: begin
        r_d    = RW'(mag);
        flag_d = diff[WIDTH];
      end
      default: r_d = RW'(prod);
    endcase
  end

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  logic [8*NDIGITS-1:0] hex_d, hex_q;
  logic                 seen_nz;

  // Scan from the top digit so a digit blanks only when everything above is zero too.
  always_comb begin
    hex_d   = '1;
    seen_nz = 1'b0;
    for (int d = NDIGITS - 1; d >= 0; d--) begin
      seen_nz = seen_nz | (r_q[4*d +: 4] != 4'h0);
      if (LZ_BLANK != 0 && d != 0 && !seen_nz) hex_d[8*d +: 8] = 8'hFF;
      else                                     hex_d[8*d +: 8] = glyph(r_q[4*d +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      flag_q <= 1'b0;
      hex_q  <= '1;
    end else begin
      r_q    <= r_d;
      flag_q <= flag_d;
      hex_q  <= hex_d;
    end
  end

  assign hex      = hex_q;
  assign mode_led = mode_q;
  assign flag_led = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_alu_display.sv
`default_nettype none
// -------------------------------------------------------------------------
// tb_sw_alu_display : directed bench for sw_alu_display (two instances, LZ_BLANK 0/1)
// Rev 1.0 - initial release
// -------------------------------------------------------------------------
module tb_sw_alu_display;

  logic        clk;
  logic        rst_n, rst_n_b;
  logic [9:0]  sw, sw_b;
  logic [1:0]  key, key_b;
  logic [31:0] hex, hex_b;
  logic [1:0]  mode_led, mode_led_b;
  logic        flag_led, flag_led_b;

  int n_cmp = 0;
  int n_err = 0;

  sw_alu_display #(.WIDTH(5), .NDIGITS(4), .DEBOUNCE_CYCLES(4), .LZ_BLANK(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key(key),
    .hex(hex), .mode_led(mode_led), .flag_led(flag_led)
  );

  sw_alu_display #(.WIDTH(5), .NDIGITS(4), .DEBOUNCE_CYCLES(4), .LZ_BLANK(1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n_b), .sw(sw_b), .key(key_b),
    .hex(hex_b), .mode_led(mode_led_b), .flag_led(flag_led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] mask);
    key = ~mask;
    tick(10);
    key = 2'b11;
    tick(10);
  endtask

  task automatic set_ab(input logic [4:0] a, input logic [4:0] b);
    sw = {b, a};
    tick(4);
  endtask

  initial begin
    rst_n   = 1'b0;  rst_n_b = 1'b0;
    sw      = 10'h2B5; sw_b = 10'h155;
    key     = 2'b00;  key_b  = 2'b00;
    tick(3);
    chk("rst_hex",    hex,        32'hFFFF_FFFF);
    chk("rst_mode",   mode_led,   2'b00);
    chk("rst_flag",   flag_led,   1'b0);
    chk("rst_hex_lz", hex_b,      32'hFFFF_FFFF);

    sw = '0; sw_b = '0; key = 2'b11; key_b = 2'b11;
    rst_n = 1'b1; rst_n_b = 1'b1;
    tick(4);
    chk("zero_hex",    hex,   32'hC0C0_C0C0);
    chk("zero_hex_lz", hex_b, 32'hFFFF_FFC0);

    key[0] = 1'b0; tick(3); key[0] = 1'b1; tick(10);
    chk("glitch_mode", mode_led, 2'b00);

    key[0] = 1'b0;
    tick(6);
    chk("press_early", mode_led, 2'b00);
    tick(1);
    chk("press_exact", mode_led, 2'b01);
    tick(50);
    chk("press_hold", mode_led, 2'b01);
    key[0] = 1'b1; tick(10);
    chk("release", mode_led, 2'b01);

    set_ab(5'd31, 5'd1);
    chk("add_31_1",  hex,      32'hC0C0_A4C0);
    chk("add_cflag", flag_led, 1'b1);
    set_ab(5'd3, 5'd4);
    chk("add_3_4",   hex,      32'hC0C0_C0F8);
    chk("add_nflag", flag_led, 1'b0);

    press(2'b01);
    chk("back_to_00", mode_led, 2'b00);
    press(2'b11);
    chk("both_keys", mode_led, 2'b11);
    set_ab(5'd31, 5'd31);
    chk("mul_31_31", hex,      32'hC0B0_C6F9);
    chk("mul_flag",  flag_led, 1'b0);

    press(2'b01);
    chk("to_sub", mode_led, 2'b10);
    set_ab(5'd2, 5'd5);
    chk("sub_2_5",    hex,      32'hC0C0_C0B0);
    chk("sub_nflag",  flag_led, 1'b1);
    set_ab(5'd5, 5'd5);
    chk("sub_eq",     hex,      32'hC0C0_C0C0);
    chk("sub_eqflag", flag_led, 1'b0);
    set_ab(5'd31, 5'd0);
    chk("sub_31_0",   hex,      32'hC0C0_F98E);
    chk("sub_pflag",  flag_led, 1'b0);

    sw_b = {5'd0, 5'd5}; tick(4);
    chk("lz_a5", hex_b, 32'hFFFF_FF92);
    sw_b = {5'd1, 5'd0}; tick(4);
    chk("lz_inner0", hex_b, 32'hFFFF_A4C0);

    key_b[0] = 1'b0; tick(4);
    rst_n_b = 1'b0; tick(1);
    chk("lz_rst_hex", hex_b, 32'hFFFF_FFFF);
    key_b = 2'b11; tick(1);
    rst_n_b = 1'b1; tick(12);
    chk("rst_discard", mode_led_b, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
